sif_xlat_bridge: RTL and testbench

//  Parametrised SIF bridge between the XA host port and the WA write-forward port.
//  XA writes are buffered in a FIFO and drained to WA under a wa_ready handshake.
//  XA reads return the bit-translated address after a configurable latency, or a status word.

---
 rtl/sif_xlat_bridge_pkg.sv | 21 ++
 rtl/sif_xlat_bridge_if.sv | 29 ++
 rtl/sif_xlat_bridge_sync_fifo.sv | 48 ++++
 rtl/sif_xlat_bridge.sv | 91 +++++++++
 tb/tb_sif_xlat_bridge.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/sif_xlat_bridge_pkg.sv
// Shared types, defaults and the address bit-translation used by the SIF bridge.
package sif_xlat_bridge_pkg;

    localparam logic [15:0] STATUS_ADDR_DEFAULT = 16'hFFFF;
    localparam int          STATUS_OVF_W        = 1;

    // Status word is {zero-pad, level, ovf}; level needs one extra bit to hold a full count.
    function automatic int status_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Only bits 8 and 7 change; the rest of the address passes through untouched.
    function automatic logic [8:0] xlat(input logic [8:0] a);
        logic [8:0] r;
        r    = a;
        r[8] = a[8] ^ a[4];
        r[7] = a[7] ^ a[5];
        return r;
    endfunction

endpackage

// File: rtl/sif_xlat_bridge_if.sv
// XA host port and WA write-forward port of the SIF bridge, bundled as one bus.
interface sif_xlat_bridge_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          xa_wr_s;
    logic          xa_rd_s;
    logic [AW-1:0] xa_addr;
    logic [DW-1:0] xa_data_wr;
    logic [DW-1:0] xa_data_rd;
    logic          xa_rd_valid;
    logic          xa_full;
    logic          wa_wr_s;
    logic [AW-1:0] wa_addr;
    logic [DW-1:0] wa_data_wr;
    logic          wa_ready;
    logic          ovf;

    modport slave (
        input  xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, wa_ready,
        output xa_data_rd, xa_rd_valid, xa_full, wa_wr_s, wa_addr, wa_data_wr, ovf
    );

    modport master (
        output xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, wa_ready,
        input  xa_data_rd, xa_rd_valid, xa_full, wa_wr_s, wa_addr, wa_data_wr, ovf
    );

endinterface

// File: rtl/sif_xlat_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO; dout is the head entry whenever empty is low.
module sif_sync_fifo #(
    parameter int  W     = 32,
    parameter int  DEPTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [PW:0]  level
);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_pop;
    logic         do_push;

    // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[PW-1:0]];

    // A pop frees the head slot in the same cycle, so a push into a full FIFO may proceed.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/sif_xlat_bridge.sv
// SIF bridge: buffers XA writes towards WA and answers XA reads with translated address or status.
module sif_xlat_bridge
    import sif_xlat_bridge_pkg::*;
#(
    parameter int            AW          = 16,
    parameter int            DW          = 16,
    parameter int            FIFO_DEPTH  = 8,
    parameter int            RD_LAT      = 1,
    parameter logic [AW-1:0] STATUS_ADDR = AW'(STATUS_ADDR_DEFAULT)
) (
    input logic              clk,
    input logic              rst,
    sif_xlat_bridge_if.slave bus
);

    localparam int LVL_W = status_level_w(FIFO_DEPTH);
    localparam int EW    = AW + DW;

    logic [EW-1:0]    head;
    logic             full;
    logic             empty;
    logic             pop;
    logic             drop;
    logic [LVL_W-1:0] level;
    logic             ovf_q;
    logic             status_rd;
    logic [AW-1:0]    addr_x;
    logic [DW-1:0]    rd_word;
    logic [RD_LAT:0]          pipe_v;
    logic [RD_LAT:0][DW-1:0]  pipe_d;

    assign pop  = bus.wa_ready && !empty;
    assign drop = bus.xa_wr_s && full && !pop;

    sif_sync_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.xa_wr_s),
        .pop   (pop),
        .din   ({bus.xa_addr, bus.xa_data_wr}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Head is masked while empty so stale memory never shows on the WA port.
    assign bus.xa_full    = full;
    assign bus.wa_wr_s    = !empty;
    assign bus.wa_addr    = empty ? '0 : head[EW-1:DW];
    assign bus.wa_data_wr = empty ? '0 : head[DW-1:0];
    assign bus.ovf        = ovf_q;

    assign status_rd = bus.xa_rd_s && (bus.xa_addr == STATUS_ADDR);

    always_comb begin
        addr_x      = bus.xa_addr;
        addr_x[8:0] = xlat(bus.xa_addr[8:0]);
    end

    // Status reflects level and ovf as they stand before this edge's push, pop or clear.
    assign rd_word = status_rd ? DW'({level, ovf_q}) : DW'(addr_x);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (status_rd) begin
            ovf_q <= 1'b0;
        end
    end

    // Stage 0 is loaded at the capture edge, so the last stage lands RD_LAT edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            pipe_d <= '0;
        end else begin
            pipe_v <= {pipe_v[RD_LAT-1:0], bus.xa_rd_s};
            pipe_d <= {pipe_d[RD_LAT-1:0], (bus.xa_rd_s ? rd_word : DW'(0))};
        end
    end

    assign bus.xa_rd_valid = pipe_v[RD_LAT];
    assign bus.xa_data_rd  = pipe_d[RD_LAT];

endmodule

// File: tb/tb_sif_xlat_bridge.sv
// Drives two bridges (read latency 1 and 3) with shared stimulus and checks both against a queue model.
module tb_sif_xlat_bridge;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        wr_i = 1'b0;
    logic        rd_i = 1'b0;
    logic [15:0] addr_i = '0;
    logic [15:0] data_i = '0;
    logic        ready_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] fq[$];
    rd_t         rq1[$];
    rd_t         rq3[$];
    logic        ovf_m = 1'b0;

    always #5 clk = ~clk;

    sif_xlat_bridge_if #(.AW(16), .DW(16)) bus1 ();
    sif_xlat_bridge_if #(.AW(16), .DW(16)) bus3 ();

    assign bus1.xa_wr_s = wr_i;     assign bus3.xa_wr_s = wr_i;
    assign bus1.xa_rd_s = rd_i;     assign bus3.xa_rd_s = rd_i;
    assign bus1.xa_addr = addr_i;   assign bus3.xa_addr = addr_i;
    assign bus1.xa_data_wr = data_i; assign bus3.xa_data_wr = data_i;
    assign bus1.wa_ready = ready_i; assign bus3.wa_ready = ready_i;

    sif_xlat_bridge #(.RD_LAT(1)) dut1 (.clk(clk), .rst(rst_i), .bus(bus1));
    sif_xlat_bridge #(.RD_LAT(3)) dut3 (.clk(clk), .rst(rst_i), .bus(bus3));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bit 8 flips when bit 4 is set, bit 7 flips when bit 5 is set.
    function automatic logic [15:0] refXlat(input logic [15:0] a);
        return a ^ (a[4] ? 16'h0100 : 16'h0000) ^ (a[5] ? 16'h0080 : 16'h0000);
    endfunction

    task automatic modelEdge();
        logic        status;
        logic        popm;
        logic        fullm;
        logic        dropm;
        logic [15:0] d;
        cyc++;
        if (rst_i) begin
            fq.delete();
            rq1.delete();
            rq3.delete();
            ovf_m = 1'b0;
            return;
        end
        status = rd_i && (addr_i == 16'hFFFF);
        if (rd_i) begin
            d = status ? 16'((fq.size() * 2) + int'(ovf_m)) : refXlat(addr_i);
            rq1.push_back('{due: cyc + 1, data: d});
            rq3.push_back('{due: cyc + 3, data: d});
        end
        popm  = ready_i && (fq.size() > 0);
        fullm = (fq.size() == 8);
        dropm = wr_i && fullm && !popm;
        if (popm) void'(fq.pop_front());
        if (wr_i && !dropm) fq.push_back({addr_i, data_i});
        if (dropm) ovf_m = 1'b1;
        else if (status) ovf_m = 1'b0;
    endtask

    task automatic compareAll();
        logic        ev;
        logic [15:0] ed;
        ev = 1'b0; ed = '0;
        if (rq1.size() > 0 && rq1[0].due == cyc) begin
            ev = 1'b1; ed = rq1[0].data; void'(rq1.pop_front());
        end
        checkOutput("rd_valid_lat1", 32'(bus1.xa_rd_valid), 32'(ev));
        checkOutput("rd_data_lat1", 32'(bus1.xa_data_rd), 32'(ed));
        ev = 1'b0; ed = '0;
        if (rq3.size() > 0 && rq3[0].due == cyc) begin
            ev = 1'b1; ed = rq3[0].data; void'(rq3.pop_front());
        end
        checkOutput("rd_valid_lat3", 32'(bus3.xa_rd_valid), 32'(ev));
        checkOutput("rd_data_lat3", 32'(bus3.xa_data_rd), 32'(ed));
        checkOutput("wa_wr_s", 32'(bus1.wa_wr_s), 32'(fq.size() > 0));
        checkOutput("wa_head", {bus1.wa_addr, bus1.wa_data_wr}, (fq.size() > 0) ? fq[0] : 32'h0);
        checkOutput("xa_full", 32'(bus1.xa_full), 32'(fq.size() == 8));
        checkOutput("ovf", 32'(bus1.ovf), 32'(ovf_m));
        checkOutput("wa_head_lat3", {bus3.wa_wr_s, bus3.wa_addr, bus3.wa_data_wr[14:0]},
                    {bus1.wa_wr_s, bus1.wa_addr, bus1.wa_data_wr[14:0]});
    endtask

    // Called at a negedge; drives inputs, lets one posedge happen, checks at the following negedge.
    task automatic applyStimulus(input logic r, input logic w, input logic rd, input logic [15:0] a,
                                 input logic [15:0] d, input logic rdy);
        rst_i = r; wr_i = w; rd_i = rd; addr_i = a; data_i = d; ready_i = rdy;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareAll();
    endtask

    initial begin
        @(negedge clk);
        applyStimulus(1, 0, 0, 16'h0, 16'h0, 0);
        applyStimulus(1, 0, 0, 16'h0, 16'h0, 0);
        checkOutput("reset_rd_valid", 32'(bus1.xa_rd_valid), 32'h0);
        checkOutput("reset_wa_wr_s", 32'(bus1.wa_wr_s), 32'h0);

        // Plain translated reads, streamed back to back.
        applyStimulus(0, 0, 1, 16'h0110, 16'h0, 0);
        applyStimulus(0, 0, 1, 16'h0030, 16'h0, 0);
        applyStimulus(0, 0, 0, 16'h0000, 16'h0, 0);
        checkOutput("xlat_0030", {15'h0, bus1.xa_rd_valid, bus1.xa_data_rd}, {15'h0, 1'b1, 16'h01B0});
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 16'($urandom), 16'h0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 16'h0, 16'h0, 0);

        // Fill with WA stalled, then overflow once.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 1, 0, 16'(16'h1000 + i), 16'($urandom), 0);
            if (i == 7) checkOutput("full_after_8", 32'(bus1.xa_full), 32'h1);
        end
        checkOutput("ovf_after_drop", 32'(bus1.ovf), 32'h1);

        applyStimulus(0, 0, 1, 16'hFFFF, 16'h0, 0);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0);
        checkOutput("status_full_ovf", 32'(bus1.xa_data_rd), 32'h0011);
        applyStimulus(0, 0, 1, 16'hFFFF, 16'h0, 0);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 0);
        checkOutput("status_ovf_clr", 32'(bus1.xa_data_rd), 32'h0010);

        // Push into a full FIFO while popping is accepted.
        applyStimulus(0, 1, 0, 16'h00A5, 16'h5A5A, 1);
        checkOutput("full_push_pop_ovf", 32'(bus1.ovf), 32'h0);
        checkOutput("full_push_pop_full", 32'(bus1.xa_full), 32'h1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 16'h0, 16'h0, 1);
        checkOutput("drained", 32'(bus1.wa_wr_s), 32'h0);

        // Reset in the middle of a read burst and a drain.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 16'(16'h2000 + i), 16'($urandom), 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 16'(16'h0020 + i), 16'h0, 1);
        applyStimulus(1, 0, 1, 16'h0030, 16'h0, 1);
        checkOutput("midrst_valid1", 32'(bus1.xa_rd_valid), 32'h0);
        checkOutput("midrst_valid3", 32'(bus3.xa_rd_valid), 32'h0);
        checkOutput("midrst_wa", 32'(bus1.wa_wr_s), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 16'h0, 16'h0, 0);
        checkOutput("postrst_valid3", 32'(bus3.xa_rd_valid), 32'h0);

        // Random traffic with phases of differing WA backpressure.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 600; i++) begin
                applyStimulus(($urandom_range(0, 199) == 0),
                              1'($urandom_range(0, 1)),
                              ($urandom_range(0, 2) != 0),
                              ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom),
                              16'($urandom),
                              ($urandom_range(0, 3) < p));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
